// File: rtl/dual_input_debouncer.sv
// Two-channel switch/button debouncer feeding a 2-input gate block.
// Each channel: 2-flop synchroniser followed by a 4-state debounce FSM
// with a restartable stability counter. Channels are independent lanes.
// Optional feature macro: DEBOUNCE_EDGE_PULSE_EN adds registered a_rise/b_rise
// one-cycle pulses on each clean 0->1 transition.

module debounce_lane #(
  parameter int DEBOUNCE_CNT = 50000,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic rise,
`endif
  output logic clean
);

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             s1, s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; only s2 is allowed into the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce FSM: any disagreement during a WAIT state drops back and
  // zeroes the count, so only an uninterrupted run commits a level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt   <= '0;
      clean <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
      rise  <= 1'b0;
`endif
    end else begin
`ifdef DEBOUNCE_EDGE_PULSE_EN
      rise <= 1'b0;
`endif
      case (state)
        LOW: begin
          cnt <= '0;
          if (s2) state <= RISE_WAIT;
        end
        RISE_WAIT: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HIGH;
            cnt   <= '0;
            clean <= 1'b1;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise  <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          cnt <= '0;
          if (!s2) state <= FALL_WAIT;
        end
        FALL_WAIT: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= LOW;
            cnt   <= '0;
            clean <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
          clean <= 1'b0;
        end
      endcase
    end
  end

endmodule

module dual_input_debouncer #(
  parameter int DEBOUNCE_CNT = 50000,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic a_rise,
  output logic b_rise,
`endif
  output logic a_clean,
  output logic b_clean
);

  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] raw_vec;
  logic [NUM_LANES-1:0] clean_vec;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [NUM_LANES-1:0] rise_vec;
`endif

  assign raw_vec = {b_raw, a_raw};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    debounce_lane #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .CNT_W        (CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_vec[i]),
`ifdef DEBOUNCE_EDGE_PULSE_EN
      .rise  (rise_vec[i]),
`endif
      .clean (clean_vec[i])
    );
  end

  assign a_clean = clean_vec[0];
  assign b_clean = clean_vec[1];
`ifdef DEBOUNCE_EDGE_PULSE_EN
  assign a_rise  = rise_vec[0];
  assign b_rise  = rise_vec[1];
`endif

endmodule
